muldiv_arbiter: RTL and testbench
=================================

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning operand width; the result width is 2*DW.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_i  input  2  per-requester operation request (bit0 = pipe 0, bit1 = pipe 1); held until done.
REQ-005 SHALL have port div_i  input  2  per-requester op select: 1 = divide, 0 = multiply.
REQ-006 SHALL have port sign_i  input  2  per-requester signed (1) or unsigned (0) operation.
REQ-007 SHALL have ports opa0_i, opb0_i, opa1_i, opb1_i  input  DW each  requester operands.
REQ-008 SHALL have port kill_i  input  2  per-requester flush (exception or branch kill).
REQ-009 SHALL have ports mul_start_o, div_start_o, unit_sign_o  output  1 each  unit control.
REQ-010 SHALL have ports unit_opa_o, unit_opb_o  output  DW each  latched operands to the unit.
REQ-011 SHALL have port unit_flush_o  output  1  one-cycle abort to the unit.
REQ-012 SHALL have ports mul_ready_i, div_ready_i  input  1 each, and mul_res_i, div_res_i  input  2*DW each.
REQ-013 SHALL have port done_o  output  2  one-cycle completion strobe per requester.
REQ-014 SHALL have port result_o  output  2*DW  captured result, valid while done_o is nonzero.
REQ-015 SHALL have port stall_o  output  2  per-requester stall: req_i[i] & ~done_o[i].
REQ-016 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 IDLE: if any unkilled request exists, SHALL pick a winner, latch its operands, op, sign and owner, and move to RUN; otherwise SHALL stay in IDLE.
REQ-019 A request whose kill_i bit is high in the same cycle SHALL NOT be granted.
REQ-020 RUN: SHALL hold mul_start_o or div_start_o (per the latched op) high continuously, with unit_sign_o and the operand outputs constant.
REQ-021 RUN: when the selected unit's ready is high, SHALL capture its result into result_o, drop start in that same cycle (combinational on ready), and move to DONE.
REQ-022 DONE: SHALL assert done_o[owner] for exactly one cycle and return to IDLE; the owner's req_i is ignored during DONE.
REQ-023 Latency: start asserted the cycle after grant; done_o asserted the cycle after unit ready.
REQ-024 kill_i[owner] in RUN SHALL drop start, pulse unit_flush_o for one cycle, and move to IDLE with no done_o.
REQ-025 kill_i[owner] in DONE SHALL suppress done_o; the FSM still returns to IDLE.
REQ-026 kill_i of the non-owner SHALL NOT affect the operation in flight.
REQ-027 The ready input of the unselected unit SHALL be ignored.
REQ-028 The non-owner's stall_o SHALL stay high while its request waits.

Reset
REQ-029 On rst, SHALL drive state to IDLE and set all outputs to 0: start, flush, done_o, result_o, operands and the priority pointer.
REQ-030 rst asserted during RUN SHALL abandon the operation with no done_o; the unit is reset by the same rst.

Configuration
REQ-031 With MULDIV_RR_EN defined, SHALL arbitrate round-robin: a one-bit pointer favours the requester not granted last, and updates on each grant.
REQ-032 Without MULDIV_RR_EN, requester 0 SHALL always win simultaneous requests.

Verification
REQ-033 req_i=01, mul, signed, opa0=-3, opb0=7; mul_ready after 4 cycles -> result_o=64'hFFFFFFFF_FFFFFFEB, done_o=01 one cycle.
REQ-034 req_i=10, divu, opa1=100, opb1=7 -> div_start_o held until ready, result_o={32'd2,32'd14}, done_o=10.
REQ-035 req_i=11 in two consecutive transactions -> without MULDIV_RR_EN pipe 0 is granted both times; with it, grants alternate 0 then 1.
REQ-036 kill_i[0] in the 2nd RUN cycle of pipe 0's divide -> unit_flush_o pulses once, no done_o, FSM returns to IDLE and pipe 1 is granted next.
REQ-037 rst asserted mid-RUN -> busy_o=0 and all outputs 0 the following cycle; a new req then completes normally.

Source files
------------

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: shares one mul/div unit pair between two pipes; MULDIV_RR_EN selects round-robin arbitration
module muldiv_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_i,
  input  logic [1:0]    div_i,
  input  logic [1:0]    sign_i,
  input  logic [DW-1:0] opa0_i,
  input  logic [DW-1:0] opb0_i,
  input  logic [DW-1:0] opa1_i,
  input  logic [DW-1:0] opb1_i,
  input  logic [1:0]    kill_i,
  output logic          mul_start_o,
  output logic          div_start_o,
  output logic          unit_sign_o,
  output logic [DW-1:0] unit_opa_o,
  output logic [DW-1:0] unit_opb_o,
  output logic          unit_flush_o,
  input  logic          mul_ready_i,
  input  logic          div_ready_i,
  input  logic [2*DW-1:0] mul_res_i,
  input  logic [2*DW-1:0] div_res_i,
  output logic [1:0]    done_o,
  output logic [2*DW-1:0] result_o,
  output logic [1:0]    stall_o,
  output logic          busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic owner, op_div, winner, kill_own, ready_sel, grant;
  logic [1:0] avail;
  assign avail = req_i & ~kill_i;
  assign grant = |avail;
  assign kill_own = kill_i[owner];
  assign ready_sel = op_div ? div_ready_i : mul_ready_i;
`ifdef MULDIV_RR_EN
  // ptr names the requester that wins a tie: the one not granted last
  logic ptr;
  assign winner = &avail ? ptr : avail[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (state == IDLE && grant) ptr <= ~winner;
`else
  assign winner = ~avail[0];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? RUN : IDLE;
      RUN:     state_nx = kill_own ? IDLE : (ready_sel ? DONE : RUN);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner       <= 1'b0;
      op_div      <= 1'b0;
      unit_sign_o <= 1'b0;
      unit_opa_o  <= '0;
      unit_opb_o  <= '0;
      result_o    <= '0;
    end else begin
      if (state == IDLE && grant) begin
        owner       <= winner;
        op_div      <= div_i[winner];
        unit_sign_o <= sign_i[winner];
        unit_opa_o  <= winner ? opa1_i : opa0_i;
        unit_opb_o  <= winner ? opb1_i : opb0_i;
      end
      if (state == RUN && !kill_own && ready_sel) result_o <= op_div ? div_res_i : mul_res_i;
    end
  // start falls combinationally on ready or kill so the unit never sees a stale start
  always_comb begin
    mul_start_o  = state == RUN && !op_div && !mul_ready_i && !kill_own;
    div_start_o  = state == RUN && op_div && !div_ready_i && !kill_own;
    unit_flush_o = state == RUN && kill_own;
    done_o       = (state == DONE && !kill_own) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    stall_o      = req_i & ~done_o;
    busy_o       = state != IDLE;
  end
endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter: directed checks of grant, latency, kill, reset and arbitration order
module tb_muldiv_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_i = '0, div_i = '0, sign_i = '0, kill_i = '0;
  logic [31:0] opa0_i = '0, opb0_i = '0, opa1_i = '0, opb1_i = '0;
  logic mul_start_o, div_start_o, unit_sign_o, unit_flush_o, busy_o;
  logic [31:0] unit_opa_o, unit_opb_o;
  logic mul_ready_i = 1'b0, div_ready_i = 1'b0;
  logic [63:0] mul_res_i = '0, div_res_i = '0, result_o;
  logic [1:0] done_o, stall_o;
  int checks = 0, errors = 0;
  logic rr;
  muldiv_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req_i), .div_i(div_i), .sign_i(sign_i),
    .opa0_i(opa0_i), .opb0_i(opb0_i), .opa1_i(opa1_i), .opb1_i(opb1_i), .kill_i(kill_i),
    .mul_start_o(mul_start_o), .div_start_o(div_start_o), .unit_sign_o(unit_sign_o),
    .unit_opa_o(unit_opa_o), .unit_opb_o(unit_opb_o), .unit_flush_o(unit_flush_o),
    .mul_ready_i(mul_ready_i), .div_ready_i(div_ready_i), .mul_res_i(mul_res_i),
    .div_res_i(div_res_i), .done_o(done_o), .result_o(result_o), .stall_o(stall_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
`ifdef MULDIV_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    step;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_outs", {29'd0, mul_start_o, div_start_o, unit_flush_o, done_o, result_o[31:0]}, 64'd0);
    check("rst_ops", {unit_opa_o, unit_opb_o}, 64'd0);
    rst = 1'b0;
    step;
    // signed multiply from pipe 0
    req_i = 2'b01; div_i = 2'b00; sign_i = 2'b01; opa0_i = 32'hFFFF_FFFD; opb0_i = 32'd7;
    #1 check("idle_stall", 64'(stall_o), 64'd1);
    step;
    check("mul_run", {60'd0, busy_o, mul_start_o, div_start_o, unit_sign_o}, 64'b1101);
    check("mul_ops", {unit_opa_o, unit_opb_o}, {32'hFFFF_FFFD, 32'd7});
    opa0_i = 32'd0;
    div_ready_i = 1'b1; div_res_i = 64'hDEAD;
    step;
    check("mul_ignore_div_rdy", {61'd0, busy_o, mul_start_o, div_start_o}, 64'b110);
    check("mul_ops_held", 64'(unit_opa_o), 64'hFFFF_FFFD);
    div_ready_i = 1'b0;
    step;
    step;
    mul_ready_i = 1'b1; mul_res_i = 64'hFFFF_FFFF_FFFF_FFEB;
    #1 check("mul_start_drop", 64'(mul_start_o), 64'd0);
    check("mul_no_done_yet", 64'(done_o), 64'd0);
    step;
    mul_ready_i = 1'b0;
    check("mul_done", 64'(done_o), 64'd1);
    check("mul_result", result_o, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_stall_done", 64'(stall_o), 64'd0);
    req_i = 2'b00;
    step;
    check("mul_done_once", {61'd0, busy_o, done_o}, 64'd0);
    // unsigned divide from pipe 1
    req_i = 2'b10; div_i = 2'b10; sign_i = 2'b00; opa1_i = 32'd100; opb1_i = 32'd7;
    step;
    check("div_run", {60'd0, busy_o, mul_start_o, div_start_o, unit_sign_o}, 64'b1010);
    check("div_ops", {unit_opa_o, unit_opb_o}, {32'd100, 32'd7});
    check("div_stall", 64'(stall_o), 64'd2);
    mul_ready_i = 1'b1;
    step;
    check("div_ignore_mul_rdy", {62'd0, busy_o, div_start_o}, 64'b11);
    mul_ready_i = 1'b0;
    step;
    div_ready_i = 1'b1; div_res_i = {32'd2, 32'd14};
    #1 check("div_start_drop", 64'(div_start_o), 64'd0);
    step;
    div_ready_i = 1'b0;
    check("div_done", 64'(done_o), 64'd2);
    check("div_result", result_o, {32'd2, 32'd14});
    req_i = 2'b00;
    step;
    check("div_idle", {61'd0, busy_o, done_o}, 64'd0);
    // simultaneous requests, two back-to-back transactions
    req_i = 2'b11; div_i = 2'b00; opa0_i = 32'd5; opb0_i = 32'd6; opa1_i = 32'd9; opb1_i = 32'd10;
    step;
    check("tie1_owner", 64'(unit_opa_o), 64'd5);
    check("tie1_stall", 64'(stall_o), 64'd3);
    mul_ready_i = 1'b1; mul_res_i = 64'd30;
    step;
    mul_ready_i = 1'b0;
    check("tie1_done", 64'(done_o), 64'd1);
    check("tie1_nonowner_stall", 64'(stall_o), 64'd2);
    step;
    check("tie1_idle", 64'(busy_o), 64'd0);
    step;
    check("tie2_owner", 64'(unit_opa_o), rr ? 64'd9 : 64'd5);
    mul_ready_i = 1'b1; mul_res_i = rr ? 64'd90 : 64'd30;
    step;
    mul_ready_i = 1'b0;
    check("tie2_done", 64'(done_o), rr ? 64'd2 : 64'd1);
    req_i = 2'b00;
    step;
    // kill of pipe 0 divide in its second RUN cycle
    req_i = 2'b11; div_i = 2'b01; opa0_i = 32'd50; opb0_i = 32'd5;
    step;
    check("kill_run1", {62'd0, div_start_o, unit_flush_o}, 64'b10);
    check("kill_owner", 64'(unit_opa_o), 64'd50);
    step;
    kill_i = 2'b01;
    #1 check("kill_flush", {61'd0, unit_flush_o, div_start_o, busy_o}, 64'b101);
    step;
    req_i = 2'b10; kill_i = 2'b00;
    check("kill_idle", {60'd0, busy_o, unit_flush_o, done_o}, 64'd0);
    step;
    check("kill_next_owner", 64'(unit_opa_o), 64'd9);
    check("kill_next_mul", 64'(mul_start_o), 64'd1);
    kill_i = 2'b01;
    #1 check("nonowner_kill", {62'd0, mul_start_o, unit_flush_o}, 64'b10);
    kill_i = 2'b00;
    mul_ready_i = 1'b1; mul_res_i = 64'd77;
    step;
    mul_ready_i = 1'b0;
    kill_i = 2'b10;
    #1 check("done_kill", {61'd0, busy_o, done_o}, 64'b100);
    step;
    kill_i = 2'b00; req_i = 2'b00;
    check("done_kill_idle", {61'd0, busy_o, done_o}, 64'd0);
    // reset in the middle of RUN
    req_i = 2'b01; div_i = 2'b00; opa0_i = 32'd2; opb0_i = 32'd3;
    step;
    step;
    check("prerst_run", 64'(mul_start_o), 64'd1);
    rst = 1'b1;
    step;
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_outs", {60'd0, mul_start_o, div_start_o, unit_flush_o, unit_sign_o}, 64'd0);
    check("rst_mid_data", {unit_opa_o, unit_opb_o} | result_o | 64'(done_o), 64'd0);
    rst = 1'b0;
    step;
    check("postrst_run", {62'd0, busy_o, mul_start_o}, 64'b11);
    check("postrst_ops", {unit_opa_o, unit_opb_o}, {32'd2, 32'd3});
    mul_ready_i = 1'b1; mul_res_i = 64'd6;
    step;
    mul_ready_i = 1'b0;
    check("postrst_done", 64'(done_o), 64'd1);
    check("postrst_result", result_o, 64'd6);
    req_i = 2'b00;
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
